// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave
// Brief    : SPI mode-0 responder, MSB first, oversampled on clk_i, with a
//            one-word transmit buffer and a pulsed receive strobe.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              sclk_i,
    input  logic              ss_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_valid_o,
    output logic              tx_underrun_o,
    output logic              busy_o
);

    localparam int                 c_cnt_w    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_W - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_ss_d;

    state_t                 r_state;
    logic [c_cnt_w-1:0]     r_bit_cnt;
    logic                   r_word_done;
    logic [DATA_W-1:0]      r_tx_buf;
    logic                   r_tx_full;
    logic [DATA_W-1:0]      r_tx_shift;
    logic [DATA_W-1:0]      r_rx_shift;
    logic [DATA_W-1:0]      r_rx_data;
    logic                   r_rx_valid;
    logic                   r_tx_underrun;
    logic                   r_miso_oe;

    logic                   w_sclk;
    logic                   w_ss_n;
    logic                   w_mosi;
    logic                   w_sclk_rise;
    logic                   w_sclk_fall;
    logic                   w_ss_fall;
    logic                   w_ss_rise;
    logic                   w_tx_load;
    logic [DATA_W-1:0]      w_next_word;

    // Synchronizers reset to the bus idle levels so release never fakes an edge
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_i};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_n_i};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_ss_d      <= r_ss_sync[SYNC_STAGES-1];
        end
    end

    assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss_n      = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk & r_sclk_d;
    assign w_ss_fall   = ~w_ss_n & r_ss_d;
    assign w_ss_rise   = w_ss_n & ~r_ss_d;
    assign w_tx_load   = tx_valid_i & ~r_tx_full;
    assign w_next_word = r_tx_full ? r_tx_buf : '0;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= '0;
            r_word_done   <= 1'b0;
            r_tx_buf      <= '0;
            r_tx_full     <= 1'b0;
            r_tx_shift    <= '0;
            r_rx_shift    <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            r_miso_oe     <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_tx_underrun <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_ss_fall) begin
                        r_state       <= S_ACTIVE;
                        r_bit_cnt     <= '0;
                        r_word_done   <= 1'b0;
                        r_miso_oe     <= 1'b1;
                        r_tx_shift    <= w_next_word;
                        r_tx_full     <= 1'b0;
                        r_tx_underrun <= ~r_tx_full;
                    end
                end
                S_ACTIVE: begin
                    // Deselect outranks any sclk edge seen in the same cycle
                    if (w_ss_rise) begin
                        r_state     <= S_IDLE;
                        r_bit_cnt   <= '0;
                        r_rx_shift  <= '0;
                        r_word_done <= 1'b0;
                        r_miso_oe   <= 1'b0;
                        r_tx_shift  <= '0;
                    end else if (w_sclk_rise) begin
                        r_rx_shift <= {r_rx_shift[DATA_W-2:0], w_mosi};
                        if (r_bit_cnt == c_last_bit) begin
                            r_bit_cnt   <= '0;
                            r_word_done <= 1'b1;
                            r_rx_data   <= {r_rx_shift[DATA_W-2:0], w_mosi};
                            r_rx_valid  <= 1'b1;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else if (w_sclk_fall) begin
                        if (r_word_done) begin
                            r_word_done   <= 1'b0;
                            r_tx_shift    <= w_next_word;
                            r_tx_full     <= 1'b0;
                            r_tx_underrun <= ~r_tx_full;
                        end else begin
                            r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            // A load only happens into an empty buffer, so any same-cycle
            // consume above has already taken the old (empty) contents.
            if (w_tx_load) begin
                r_tx_buf  <= tx_data_i;
                r_tx_full <= 1'b1;
            end
        end
    end

    assign miso_o        = r_tx_shift[DATA_W-1];
    assign miso_oe_o     = r_miso_oe;
    assign tx_ready_o    = ~r_tx_full;
    assign rx_data_o     = r_rx_data;
    assign rx_valid_o    = r_rx_valid;
    assign tx_underrun_o = r_tx_underrun;
    assign busy_o        = (r_state == S_ACTIVE);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave
// Brief    : Drives spi_slave as a mode-0 master; checks against a
//            transaction-level model of buffer, words and select latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

    localparam int DW   = 8;
    localparam int SYNC = 2;
    localparam int HP   = 6;

    logic          clk_i      = 1'b0;
    logic          reset_i    = 1'b1;
    logic          sclk_i     = 1'b0;
    logic          ss_n_i     = 1'b1;
    logic          mosi_i     = 1'b0;
    logic [DW-1:0] tx_data_i  = '0;
    logic          tx_valid_i = 1'b0;
    logic          miso_o;
    logic          miso_oe_o;
    logic          tx_ready_o;
    logic [DW-1:0] rx_data_o;
    logic          rx_valid_o;
    logic          tx_underrun_o;
    logic          busy_o;

    spi_slave #(.DATA_W(DW), .SYNC_STAGES(SYNC)) u_dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .sclk_i        (sclk_i),
        .ss_n_i        (ss_n_i),
        .mosi_i        (mosi_i),
        .miso_o        (miso_o),
        .miso_oe_o     (miso_oe_o),
        .tx_data_i     (tx_data_i),
        .tx_valid_i    (tx_valid_i),
        .tx_ready_o    (tx_ready_o),
        .rx_data_o     (rx_data_o),
        .rx_valid_o    (rx_valid_o),
        .tx_underrun_o (tx_underrun_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int            n_checks      = 0;
    int            n_errors      = 0;
    int            exp_underrun  = 0;
    int            seen_underrun = 0;
    int            rx_pulses     = 0;
    logic [DW-1:0] exp_rx[$];
    logic [DW-1:0] mdl_buf       = '0;
    logic          mdl_full      = 1'b0;
    logic [DW-1:0] mdl_rx_data   = '0;
    logic          run_chk       = 1'b0;
    logic          exp_busy;
    logic [SYNC:0] ss_hist;
    logic [DW-1:0] fr_mosi[4];
    logic [DW-1:0] fr_got[4];
    logic [DW-1:0] fr_ld_val[4];
    logic          fr_ld_en[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Select reaches the state machine SYNC_STAGES+1 cycles after the pin moves
    always @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) ss_hist <= '1;
        else          ss_hist <= {ss_hist[SYNC-1:0], ss_n_i};
    end

    always @(negedge clk_i) begin
        if (reset_i && run_chk) begin
            exp_busy = ~ss_hist[SYNC];
            chk("busy", busy_o, exp_busy);
            chk("miso_oe", miso_oe_o, exp_busy);
            if (!exp_busy) chk("miso_idle", miso_o, 1'b0);
            if (rx_valid_o) begin
                rx_pulses++;
                if (exp_rx.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rx_valid_unexpected: got pulse with data 0x%0h expected none at %0t",
                             rx_data_o, $time);
                end else begin
                    mdl_rx_data = exp_rx.pop_front();
                end
            end
            chk("rx_data", rx_data_o, mdl_rx_data);
            if (tx_underrun_o) seen_underrun++;
        end
    end

    task automatic mdl_word_start(output logic [DW-1:0] w);
        if (mdl_full) begin
            w        = mdl_buf;
            mdl_full = 1'b0;
        end else begin
            w = '0;
            exp_underrun++;
        end
    endtask

    task automatic mdl_reset();
        exp_rx.delete();
        mdl_full    = 1'b0;
        mdl_rx_data = '0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_miso"},     miso_o,        1'b0);
        chk({tag, "_miso_oe"},  miso_oe_o,     1'b0);
        chk({tag, "_tx_ready"}, tx_ready_o,    1'b1);
        chk({tag, "_rx_data"},  rx_data_o,     8'h00);
        chk({tag, "_rx_valid"}, rx_valid_o,    1'b0);
        chk({tag, "_underrun"}, tx_underrun_o, 1'b0);
        chk({tag, "_busy"},     busy_o,        1'b0);
    endtask

    task automatic load_tx(input logic [DW-1:0] d);
        chk("tx_ready_pre_load", tx_ready_o, 1'b1);
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        mdl_buf    = d;
        mdl_full   = 1'b1;
        wait_n(1);
        tx_valid_i = 1'b0;
        chk("tx_ready_post_load", tx_ready_o, 1'b0);
    endtask

    task automatic clear_frame();
        for (int w = 0; w < 4; w++) begin
            fr_mosi[w]   = '0;
            fr_got[w]    = '0;
            fr_ld_val[w] = '0;
            fr_ld_en[w]  = 1'b0;
        end
    endtask

    // kind: 0 full frame, 1 deselect after `cut` rises, 2 reset after `cut` rises.
    // The final fall and deselect move together, so a frame never starts a spare word.
    task automatic do_frame(input int nw, input int kind, input int cut);
        logic [DW-1:0] expw;
        logic [DW-1:0] got;
        ss_n_i = 1'b0;
        mosi_i = fr_mosi[0][DW-1];
        mdl_word_start(expw);
        got = '0;
        wait_n(HP);
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < DW; b++) begin
                got[DW-1-b] = miso_o;
                sclk_i = 1'b1;
                if (b == DW-1) exp_rx.push_back(fr_mosi[w]);
                if (b == 2 && fr_ld_en[w]) begin
                    load_tx(fr_ld_val[w]);
                    wait_n(HP-1);
                end else begin
                    wait_n(HP);
                end
                if (kind != 0 && b == cut-1) begin
                    sclk_i = 1'b0;
                    if (kind == 1) begin
                        wait_n(HP);
                        ss_n_i = 1'b1;
                        mosi_i = 1'b0;
                    end else begin
                        reset_i = 1'b0;
                        mdl_reset();
                        #1;
                        check_reset_vals("t6_mid_word");
                        ss_n_i = 1'b1;
                        mosi_i = 1'b0;
                        wait_n(3);
                        reset_i = 1'b1;
                    end
                    return;
                end
                sclk_i = 1'b0;
                if (b == DW-1) begin
                    chk("miso_word", got, expw);
                    fr_got[w] = got;
                    if (w == nw-1) begin
                        ss_n_i = 1'b1;
                        mosi_i = 1'b0;
                    end else begin
                        mdl_word_start(expw);
                        got    = '0;
                        mosi_i = fr_mosi[w+1][DW-1];
                        wait_n(HP);
                    end
                end else begin
                    mosi_i = fr_mosi[w][DW-2-b];
                    wait_n(HP);
                end
            end
        end
    endtask

    task automatic frame_end();
        wait_n(4*SYNC + 6);
        chk("rx_queue_drained", exp_rx.size(), 0);
        chk("underrun_count", seen_underrun, exp_underrun);
    endtask

    initial begin
        int u0;
        int p0;
        int nw;
        int kind;
        int cut;

        #2 reset_i = 1'b0;
        wait_n(3);
        check_reset_vals("t1_init");
        reset_i = 1'b1;
        wait_n(2);
        run_chk = 1'b1;

        // single word
        clear_frame();
        fr_mosi[0] = 8'h3C;
        load_tx(8'hA5);
        u0 = seen_underrun; p0 = rx_pulses;
        do_frame(1, 0, 0);
        frame_end();
        chk("t2_miso", fr_got[0], 8'hA5);
        chk("t2_rx", rx_data_o, 8'h3C);
        chk("t2_pulses", rx_pulses - p0, 1);
        chk("t2_underrun", seen_underrun - u0, 0);

        // back-to-back words
        clear_frame();
        fr_mosi[0] = 8'h01; fr_mosi[1] = 8'h80;
        fr_ld_en[0] = 1'b1; fr_ld_val[0] = 8'hC3;
        load_tx(8'h5A);
        u0 = seen_underrun; p0 = rx_pulses;
        do_frame(2, 0, 0);
        frame_end();
        chk("t3_miso0", fr_got[0], 8'h5A);
        chk("t3_miso1", fr_got[1], 8'hC3);
        chk("t3_rx", rx_data_o, 8'h80);
        chk("t3_pulses", rx_pulses - p0, 2);
        chk("t3_underrun", seen_underrun - u0, 0);
        chk("t3_tx_ready", tx_ready_o, 1'b1);

        // underrun
        clear_frame();
        fr_mosi[0] = 8'hE7;
        u0 = seen_underrun;
        do_frame(1, 0, 0);
        frame_end();
        chk("t4_miso", fr_got[0], 8'h00);
        chk("t4_underrun", seen_underrun - u0, 1);
        chk("t4_rx", rx_data_o, 8'hE7);

        // abort after five bits, then a clean frame
        clear_frame();
        fr_mosi[0] = 8'hFF;
        p0 = rx_pulses;
        do_frame(1, 1, 5);
        frame_end();
        chk("t5_pulses", rx_pulses - p0, 0);
        chk("t5_miso_oe", miso_oe_o, 1'b0);
        chk("t5_rx_held", rx_data_o, 8'hE7);
        clear_frame();
        fr_mosi[0] = 8'h96;
        load_tx(8'h69);
        do_frame(1, 0, 0);
        frame_end();
        chk("t5_rx", rx_data_o, 8'h96);
        chk("t5_miso", fr_got[0], 8'h69);

        // reset after three bits
        clear_frame();
        fr_mosi[0] = 8'hAA;
        load_tx(8'h11);
        do_frame(1, 2, 3);
        frame_end();
        clear_frame();
        fr_mosi[0] = 8'h3C;
        load_tx(8'h22);
        p0 = rx_pulses;
        do_frame(1, 0, 0);
        frame_end();
        chk("t6_rx", rx_data_o, 8'h3C);
        chk("t6_miso", fr_got[0], 8'h22);
        chk("t6_pulses", rx_pulses - p0, 1);

        // randomized frames
        for (int i = 0; i < 12; i++) begin
            nw = $urandom_range(1, 3);
            clear_frame();
            for (int w = 0; w < nw; w++) begin
                fr_mosi[w]   = DW'($urandom);
                fr_ld_en[w]  = ($urandom_range(0, 1) == 1);
                fr_ld_val[w] = DW'($urandom);
            end
            kind = (nw == 1 && $urandom_range(0, 3) == 0) ? 1 : 0;
            cut  = $urandom_range(1, DW-1);
            if (mdl_full) chk("tx_ready_while_full", tx_ready_o, 1'b0);
            else if ($urandom_range(0, 3) != 0) load_tx(DW'($urandom));
            do_frame(nw, kind, cut);
            frame_end();
        end

        run_chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
